// File: rtl/cordic_pkg.sv
// Shared constants, FSM encoding and arctangent table for the CORDIC sin/cos sequencer.
// Angles are signed Q16.16 degrees; unit amplitude is 65536.
package cordic_pkg;

  localparam logic signed [31:0] DEG_90   = 32'sd5898240;
  localparam logic signed [31:0] DEG_180  = 32'sd11796480;
  localparam logic signed [31:0] DEG_360  = 32'sd23592960;
  localparam logic signed [31:0] CORDIC_K = 32'sd39797;
  localparam logic signed [31:0] UNIT_POS = 32'sd65536;
  localparam logic signed [31:0] UNIT_NEG = -32'sd65536;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  // atan(2^-i) in degrees, Q16.16, rounded to nearest
  localparam logic signed [31:0] ATAN_TABLE [16] = '{
    32'sd2949120, 32'sd1740967, 32'sd919879, 32'sd466945,
    32'sd234379,  32'sd117304,  32'sd58666,  32'sd29335,
    32'sd14668,   32'sd7334,    32'sd3667,   32'sd1833,
    32'sd917,     32'sd458,     32'sd229,    32'sd115
  };

  function automatic logic signed [31:0] sat_unit(input logic signed [31:0] v);
    if (v > UNIT_POS)
      return UNIT_POS;
    else if (v < UNIT_NEG)
      return UNIT_NEG;
    else
      return v;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational lookup of the CORDIC rotation angle for iteration idx.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic        [3:0]  idx,
  output logic signed [31:0] atan
);

  always_comb begin
    atan = ATAN_TABLE[idx];
  end

endmodule

// File: rtl/cordic_sincos_ctrl.sv
// Sequencer for a single shared CORDIC shift-add datapath computing sin/cos of a Q16.16 degree angle.
// Define CORDIC_SAT_EN to clamp the results to [-1.0, +1.0] in the fix-up stage.
module cordic_sincos_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] theta_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sin_out,
  output logic [31:0] cos_out,
  output logic        range_err
);

  state_t state, state_nxt;

  logic signed [31:0] theta_q;
  logic signed [31:0] x_q, y_q, z_q;
  logic signed [31:0] sin_q, cos_q;
  logic        [3:0]  cnt;
  logic               neg_q, quad_q, rerr_q;
  logic               last_iter;

  logic signed [31:0] norm, a_abs, z_red;
  logic               neg_red, quad_red, rerr_red;

  logic signed [31:0] atan;
  logic signed [31:0] x_sh, y_sh;
  logic signed [31:0] x_nxt, y_nxt, z_nxt;

  logic signed [31:0] sin_raw, cos_raw, sin_fix, cos_fix;

  assign last_iter = (cnt == 4'(ITERATIONS - 1));

  cordic_atan_rom u_atan_rom (
    .idx  (cnt),
    .atan (atan)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (in_valid && in_ready) state_nxt = ST_REDUCE;
      ST_REDUCE: state_nxt = ST_ITER;
      ST_ITER:   if (last_iter) state_nxt = ST_FIX;
      ST_FIX:    state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready  = !rst;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Fold into [0,90]: one +/-360 wrap, then mirror about 90 with the
  // cosine sign carried in quad and the sine sign carried in neg.
  always_comb begin
    norm = theta_q;
    if (theta_q > DEG_180)
      norm = theta_q - DEG_360;
    else if (theta_q < -DEG_180)
      norm = theta_q + DEG_360;
    neg_red  = (norm < 0);
    a_abs    = neg_red ? -norm : norm;
    quad_red = (a_abs > DEG_90);
    z_red    = quad_red ? (DEG_180 - a_abs) : a_abs;
    rerr_red = (theta_q > DEG_360) || (theta_q < -DEG_360);
  end

  always_comb begin
    x_sh = x_q >>> cnt;
    y_sh = y_q >>> cnt;
    if (z_q >= 0) begin
      x_nxt = x_q - y_sh;
      y_nxt = y_q + x_sh;
      z_nxt = z_q - atan;
    end else begin
      x_nxt = x_q + y_sh;
      y_nxt = y_q - x_sh;
      z_nxt = z_q + atan;
    end
  end

  always_comb begin
    cos_raw = quad_q ? -x_q : x_q;
    sin_raw = neg_q  ? -y_q : y_q;
`ifdef CORDIC_SAT_EN
    cos_fix = sat_unit(cos_raw);
    sin_fix = sat_unit(sin_raw);
`else
    cos_fix = cos_raw;
    sin_fix = sin_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      theta_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      quad_q  <= 1'b0;
      rerr_q  <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready)
            theta_q <= theta_in;
        end
        ST_REDUCE: begin
          x_q    <= CORDIC_K;
          y_q    <= '0;
          z_q    <= z_red;
          cnt    <= '0;
          neg_q  <= neg_red;
          quad_q <= quad_red;
          rerr_q <= rerr_red;
        end
        ST_ITER: begin
          x_q <= x_nxt;
          y_q <= y_nxt;
          z_q <= z_nxt;
          cnt <= cnt + 4'd1;
        end
        ST_FIX: begin
          sin_q <= sin_fix;
          cos_q <= cos_fix;
        end
        default: ;
      endcase
    end
  end

  assign sin_out   = sin_q;
  assign cos_out   = cos_q;
  assign range_err = rerr_q;

endmodule

// File: tb/tb_cordic_sincos_ctrl.sv
// Self-checking bench for cordic_sincos_ctrl: a real-arithmetic sin/cos reference feeds a scoreboard queue.
module tb_cordic_sincos_ctrl;

  localparam int ITER  = 16;
  localparam int TOL   = 8;
  localparam int BOUND = 200;
  localparam int LAT   = ITER + 2;
  localparam int PER   = ITER + 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] theta_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] sin_out;
  logic [31:0] cos_out;
  logic        range_err;

  cordic_sincos_ctrl #(.ITERATIONS(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .theta_in  (theta_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sin_out   (sin_out),
    .cos_out   (cos_out),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   s;
    int   c;
    logic rerr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_cyc = 0;

  function automatic void push_exp(input int th);
    real  rad;
    exp_t e;
    rad    = (real'(th) / 65536.0) * 3.14159265358979 / 180.0;
    e.s    = int'($sin(rad) * 65536.0);
    e.c    = int'($cos(rad) * 65536.0);
    e.rerr = (th > 23592960) || (th < -23592960);
    sb.push_back(e);
  endfunction

  task automatic send(input int th, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (ok) begin
      in_valid = 1'b1;
      theta_in = th;
      @(negedge clk);
      acc_cyc  = cyc;
      in_valid = 1'b0;
      push_exp(th);
    end
  endtask

  task automatic collect(output int s, output int c, output logic r, output int lat, output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    ok  = out_valid;
    s   = int'($signed(sin_out));
    c   = int'($signed(cos_out));
    r   = range_err;
    lat = cyc - acc_cyc;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sin_out !== 32'd0 || cos_out !== 32'd0 || range_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sin=%0d cos=%0d range_err=%b, want 0 0 0 0 0",
               in_ready, out_valid, sin_out, cos_out, range_err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_angles();
    int   tbl[10] = '{0, 5898240, -8847360, 17694720, 11796480, -11796480,
                      2949120, 23592960, -23592960, -5898240};
    int   s, c, lat, d;
    logic r;
    bit   ok;
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i], ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL angle[%0d] accept: in_ready never rose", i);
        continue;
      end
      collect(s, c, r, lat, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL angle[%0d] out_valid: timed out, want high", i);
        continue;
      end
      n_cmp++;
      d = s - e.s;
      if (d > TOL || d < -TOL) begin
        n_bad++;
        $display("FAIL angle[%0d] sin: got %0d want %0d +/-%0d", i, s, e.s, TOL);
      end
      n_cmp++;
      d = c - e.c;
      if (d > TOL || d < -TOL) begin
        n_bad++;
        $display("FAIL angle[%0d] cos: got %0d want %0d +/-%0d", i, c, e.c, TOL);
      end
      n_cmp++;
      if (r !== e.rerr) begin
        n_bad++;
        $display("FAIL angle[%0d] range_err: got %b want %b", i, r, e.rerr);
      end
      n_cmp++;
      if (lat !== LAT) begin
        n_bad++;
        $display("FAIL angle[%0d] latency: got %0d want %0d", i, lat, LAT);
      end
      handshake();
    end
  endtask

  task automatic test_range_err();
    int   tbl[3] = '{26214400, -26214400, 35389440};
    int   s, c, lat, d;
    logic r;
    bit   ok;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      send(tbl[i], ok);
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL range[%0d] accept: in_ready never rose", i);
        continue;
      end
      collect(s, c, r, lat, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || r !== e.rerr) begin
        n_bad++;
        $display("FAIL range[%0d] range_err: got %b (valid=%b) want %b", i, r, ok, e.rerr);
      end
      // 540 deg is outside the defined range; only its flag is meaningful
      if (i < 2) begin
        n_cmp++;
        d = c - e.c;
        if (d > TOL || d < -TOL) begin
          n_bad++;
          $display("FAIL range[%0d] cos: got %0d want %0d +/-%0d", i, c, e.c, TOL);
        end
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int   s, c, lat, d;
    logic r;
    bit   ok;
    exp_t e;
    send(32'sd1966080, ok);
    collect(s, c, r, lat, ok);
    e = sb.pop_front();
    n_cmp++;
    d = s - e.s;
    if (!ok || d > TOL || d < -TOL) begin
      n_bad++;
      $display("FAIL hold sin: got %0d (valid=%b) want %0d", s, ok, e.s);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          int'($signed(sin_out)) !== s || int'($signed(cos_out)) !== c) begin
        n_bad++;
        $display("FAIL hold[%0d]: out_valid=%b in_ready=%b sin=%0d cos=%0d, want 1 0 %0d %0d",
                 i, out_valid, in_ready, $signed(sin_out), $signed(cos_out), s, c);
      end
    end
    handshake();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int   s, c, lat, d;
    logic r;
    bit   ok;
    exp_t e;
    send(32'sd3932160, ok);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    n_cmp++;
    if (out_valid !== 1'b0 || sin_out !== 32'd0 || cos_out !== 32'd0 || range_err !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset: out_valid=%b sin=%0d cos=%0d range_err=%b in_ready=%b, want 0 0 0 0 0",
               out_valid, sin_out, cos_out, range_err, in_ready);
    end
    rst = 1'b0;
    send(-32'sd2949120, ok);
    collect(s, c, r, lat, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || lat !== LAT) begin
      n_bad++;
      $display("FAIL after_reset latency: got %0d (valid=%b) want %0d", lat, ok, LAT);
    end
    n_cmp++;
    d = s - e.s;
    if (d > TOL || d < -TOL) begin
      n_bad++;
      $display("FAIL after_reset sin: got %0d want %0d", s, e.s);
    end
    n_cmp++;
    d = c - e.c;
    if (d > TOL || d < -TOL) begin
      n_bad++;
      $display("FAIL after_reset cos: got %0d want %0d", c, e.c);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int   tbl[3] = '{7864320, -14417920, 20971520};
    int   s, c, lat, d, prev;
    logic r;
    bit   ok;
    exp_t e;
    prev = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(tbl[i], ok);
      if (i > 0) begin
        n_cmp++;
        if (acc_cyc - prev !== PER) begin
          n_bad++;
          $display("FAIL b2b[%0d] interval: got %0d want %0d", i, acc_cyc - prev, PER);
        end
      end
      prev = acc_cyc;
      collect(s, c, r, lat, ok);
      e = sb.pop_front();
      n_cmp++;
      d = s - e.s;
      if (!ok || d > TOL || d < -TOL) begin
        n_bad++;
        $display("FAIL b2b[%0d] sin: got %0d (valid=%b) want %0d", i, s, ok, e.s);
      end
      n_cmp++;
      d = c - e.c;
      if (d > TOL || d < -TOL) begin
        n_bad++;
        $display("FAIL b2b[%0d] cos: got %0d want %0d", i, c, e.c);
      end
    end
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_angles();
    test_range_err();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
